// File: rtl/half_duplex_line_ctrl.sv
// -----------------------------------------------------------------------------
// half_duplex_line_ctrl
//
// Sequences one transaction on a shared single-wire half-duplex bus by driving
// the data input and output-enable of the downstream three-state pad buffer.
// A transaction is a driven frame (start bit, WIDTH data bits LSB first, stop
// bit). It is optionally followed by a released turnaround guard and a WIDTH-bit
// response sampled from the pad input.
//
// Every output register is loaded from the next-state decode. As a result, each
// output is aligned with the state that is current in the same cycle.
//
// Parameters:
//   WIDTH       bits per data word (tx and rx), >= 1
//   BIT_TICKS   clock cycles per bit slot, >= 2
//   TURN_TICKS  released guard cycles between tx and rx, >= 1
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   start     transaction request, sampled only in IDLE
//   rx_en     read back a response after tx (latched with start)
//   tx_data   word to transmit (latched with start)
//   line_in   synchronised bus level from the pad
//   line_out  data level to the three-state buffer
//   line_oe   output-enable to the three-state buffer (1 = drive)
//   busy      1 whenever the controller is not IDLE
//   done      one-cycle pulse at the end of a transaction
//   rx_data   last received word, LSB received first
// -----------------------------------------------------------------------------
module half_duplex_line_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned BIT_TICKS  = 4,
    parameter int unsigned TURN_TICKS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rx_en,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             line_in,
    output logic             line_out,
    output logic             line_oe,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data
);

    // One tick counter serves both bit slots and the turnaround guard.
    localparam int unsigned CNT_MAX     = (BIT_TICKS > TURN_TICKS) ? BIT_TICKS : TURN_TICKS;
    localparam int unsigned TICK_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned BIT_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned SAMPLE_TICK = BIT_TICKS / 2;

    localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(BIT_TICKS - 1);
    localparam logic [TICK_W-1:0] TURN_LAST = TICK_W'(TURN_TICKS - 1);
    localparam logic [TICK_W-1:0] SAMPLE_AT = TICK_W'(SAMPLE_TICK);
    localparam logic [BIT_W-1:0]  WORD_LAST = BIT_W'(WIDTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_TURN  = 3'd4;
    localparam logic [2:0] S_RX    = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]        state_q,    state_d;
    logic [TICK_W-1:0] tick_q,     tick_d;
    logic [BIT_W-1:0]  bit_q,      bit_d;
    logic [WIDTH-1:0]  tx_sh_q,    tx_sh_d;
    logic [WIDTH-1:0]  rx_sh_q,    rx_sh_d;
    logic              rx_flag_q,  rx_flag_d;

    logic              line_out_q, line_out_d;
    logic              line_oe_q,  line_oe_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic [WIDTH-1:0]  rx_data_q,  rx_data_d;

    logic              tick_end_c;
    logic              word_end_c;

    assign tick_end_c = (tick_q == BIT_LAST);
    assign word_end_c = (bit_q == WORD_LAST);

    // State, counters, shift registers and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_flag_q  <= 1'b0;
            line_out_q <= 1'b1;
            line_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_flag_q  <= rx_flag_d;
            line_out_q <= line_out_d;
            line_oe_q  <= line_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rx_data_q  <= rx_data_d;
        end
    end

    // Next-state, counter and shift-register decode.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_flag_d = rx_flag_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_START;
                    tx_sh_d   = tx_data;
                    rx_flag_d = rx_en;
                    rx_sh_d   = '0;
                    tick_d    = '0;
                    bit_d     = '0;
                end
            end

            S_START: begin
                if (tick_end_c) begin
                    tick_d  = '0;
                    state_d = S_DATA;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end

            // The shift register's LSB is always the bit on the wire.
            S_DATA: begin
                if (tick_end_c) begin
                    tick_d  = '0;
                    tx_sh_d = tx_sh_q >> 1;
                    if (word_end_c) begin
                        bit_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end

            S_STOP: begin
                if (tick_end_c) begin
                    tick_d  = '0;
                    state_d = rx_flag_q ? S_TURN : S_DONE;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end

            S_TURN: begin
                if (tick_q == TURN_LAST) begin
                    tick_d  = '0;
                    state_d = S_RX;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end

            // The single mid-slot sample rejects edges and glitches elsewhere in the slot.
            S_RX: begin
                if (tick_q == SAMPLE_AT) begin
                    rx_sh_d = (rx_sh_q >> 1) | (WIDTH'(line_in) << (WIDTH - 1));
                end
                if (tick_end_c) begin
                    tick_d = '0;
                    if (word_end_c) begin
                        bit_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Output decode from the next state, so that each registered output matches the state.
    always_comb begin
        line_oe_d  = 1'b0;
        line_out_d = 1'b1;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        rx_data_d  = rx_data_q;

        case (state_d)
            S_START: begin
                line_oe_d  = 1'b1;
                line_out_d = 1'b0;
            end
            S_DATA: begin
                line_oe_d  = 1'b1;
                line_out_d = tx_sh_d[0];
            end
            S_STOP: begin
                line_oe_d  = 1'b1;
                line_out_d = 1'b1;
            end
            default: begin
                line_oe_d  = 1'b0;
                line_out_d = 1'b1;
            end
        endcase

        // DONE is entered exactly once per transaction, so this loads rx_data once.
        if ((state_d == S_DONE) && (state_q != S_DONE) && rx_flag_q) begin
            rx_data_d = rx_sh_d;
        end
    end

    assign line_out = line_out_q;
    assign line_oe  = line_oe_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_data  = rx_data_q;

endmodule
